// File: rtl/chacha_column_engine.sv
// rtl/chacha_column_engine.sv - one self-sequencing ChaCha state column (rows a/b/c/d)
// Four instances with a shared start and cross-wired b/c/d words form a full ChaCha block core.
module chacha_column_engine #(
  parameter int          COL      = 0,
  parameter logic [31:0] A_INIT   = 32'h61707865,
  parameter int          ROUNDS   = 20,
  parameter int          CTR_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        ctr_inc,
  input  logic        ctr_cin,
  output logic        ctr_cout,
  output logic [31:0] b_q,
  output logic [31:0] c_q,
  output logic [31:0] d_q,
  input  logic [31:0] b_n_in,
  input  logic [31:0] b_p_in,
  input  logic [31:0] c_o_in,
  input  logic [31:0] d_p_in,
  input  logic [31:0] d_n_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_QR,
    S_SHIFT,
    S_UNSHIFT,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [1:0] COL_ID  = 2'(COL);
  localparam logic [3:0] LAST_DR = 4'(ROUNDS / 2 - 1);

  state_t      state, state_n;
  logic [31:0] a, b, c, d;
  logic [31:0] b_init, c_init, d_init;
  logic [31:0] b_wr, c_wr, d_wr, ctr_add;
  logic [31:0] ab_sum, cd_sum;
  logic [31:0] qr_a, qr_b, qr_c, qr_d;
  logic [31:0] rd_word;
  logic [1:0]  step;
  logic        diag;
  logic [3:0]  dbl_cnt;
  logic        done_r;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  assign b_q      = b;
  assign c_q      = c;
  assign d_q      = d;
  assign done     = done_r;
  assign ctr_cout = (CTR_MODE == 1) && (d_init == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Diagonal QR follows the column QR; the UNSHIFT after it closes one double round.
  always_comb begin
    state_n = state;
    busy    = (state != S_IDLE);
    case (state)
      S_IDLE:    if (start) state_n = S_LOAD;
      S_LOAD:    state_n = S_QR;
      S_QR:      if (step == 2'd3) state_n = diag ? S_UNSHIFT : S_SHIFT;
      S_SHIFT:   state_n = S_QR;
      S_UNSHIFT: state_n = (dbl_cnt == LAST_DR) ? S_ADD : S_QR;
      S_ADD:     state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  assign ab_sum = a + b;
  assign cd_sum = c + d;

  always_comb begin
    qr_a = a;
    qr_b = b;
    qr_c = c;
    qr_d = d;
    case (step)
      2'd0: begin qr_a = ab_sum; qr_d = rotl(d ^ ab_sum, 16); end
      2'd1: begin qr_c = cd_sum; qr_b = rotl(b ^ cd_sum, 12); end
      2'd2: begin qr_a = ab_sum; qr_d = rotl(d ^ ab_sum, 8);  end
      default: begin qr_c = cd_sum; qr_b = rotl(b ^ cd_sum, 7); end
    endcase
  end

  // Byte write merges before the counter add so both can land in the same cycle.
  always_comb begin
    b_wr    = b_init;
    c_wr    = c_init;
    d_wr    = d_init;
    ctr_add = 32'd0;
    if (wr_en && wr_addr[3:2] == COL_ID) begin
      case (wr_addr[5:4])
        2'd1:    b_wr[{wr_addr[1:0], 3'b000} +: 8] = wr_data;
        2'd2:    c_wr[{wr_addr[1:0], 3'b000} +: 8] = wr_data;
        2'd3:    d_wr[{wr_addr[1:0], 3'b000} +: 8] = wr_data;
        default: ;
      endcase
    end
    if (ctr_inc) begin
      if (CTR_MODE == 1)      ctr_add = 32'd1;
      else if (CTR_MODE == 2) ctr_add = {31'd0, ctr_cin};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a       <= A_INIT;
      b       <= 32'd0;
      c       <= 32'd0;
      d       <= 32'd0;
      b_init  <= 32'd0;
      c_init  <= 32'd0;
      d_init  <= 32'd0;
      step    <= 2'd0;
      diag    <= 1'b0;
      dbl_cnt <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          b_init <= b_wr;
          c_init <= c_wr;
          d_init <= d_wr + ctr_add;
        end
        S_LOAD: begin
          a       <= A_INIT;
          b       <= b_init;
          c       <= c_init;
          d       <= d_init;
          step    <= 2'd0;
          diag    <= 1'b0;
          dbl_cnt <= 4'd0;
        end
        S_QR: begin
          a    <= qr_a;
          b    <= qr_b;
          c    <= qr_c;
          d    <= qr_d;
          step <= step + 2'd1;
        end
        S_SHIFT: begin
          b    <= b_n_in;
          c    <= c_o_in;
          d    <= d_p_in;
          diag <= 1'b1;
        end
        S_UNSHIFT: begin
          b       <= b_p_in;
          c       <= c_o_in;
          d       <= d_n_in;
          diag    <= 1'b0;
          dbl_cnt <= dbl_cnt + 4'd1;
        end
        S_ADD: begin
          a <= a + A_INIT;
          b <= b + b_init;
          c <= c + c_init;
          d <= d + d_init;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (rd_addr[5:4])
      2'd1:    rd_word = b;
      2'd2:    rd_word = c;
      2'd3:    rd_word = d;
      default: rd_word = a;
    endcase
    rd_data = (rd_addr[3:2] == COL_ID) ? rd_word[{rd_addr[1:0], 3'b000} +: 8] : 8'h00;
  end

endmodule
